aes_round_ctrl: RTL and testbench

//  Sequences one AES-128 encryption over the shared round units (subbytes, shiftrows, mixcolumns, addroundkey).

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_round_ctrl_if.sv | 28 ++
 rtl/aes_op_watchdog.sv | 29 ++
 rtl/aes_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - op codes, sequencer state encodings and round count shared by the AES round controller
// ST_ERR exists only when AES_OP_TIMEOUT_EN is defined.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        OP_SB  = 2'd0,
        OP_SR  = 2'd1,
        OP_MC  = 2'd2,
        OP_ARK = 2'd3
    } aes_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
`ifdef AES_OP_TIMEOUT_EN
        ST_FIN   = 3'd3,
        ST_ERR   = 3'd4
`else
        ST_FIN   = 3'd3
`endif
    } ctrl_state_t;

    // Op that follows a completed one; the last round goes straight from SR to ARK.
    function automatic aes_op_t next_op(input aes_op_t op, input logic final_round);
        case (op)
            OP_ARK:  return OP_SB;
            OP_SB:   return OP_SR;
            OP_SR:   return final_round ? OP_ARK : OP_MC;
            default: return OP_ARK;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - op-issue bus between the round sequencer (master) and the shared round units (slave)
interface aes_round_ctrl_if;
    import aes_pkg::*;

    aes_op_t     op_sel;
    logic        op_start;
    logic [31:0] op_state0;
    logic [31:0] op_state1;
    logic [31:0] op_state2;
    logic [31:0] op_state3;
    logic [3:0]  round_idx;
    logic        op_done;
    logic [31:0] op_result0;
    logic [31:0] op_result1;
    logic [31:0] op_result2;
    logic [31:0] op_result3;

    modport master (
        output op_sel, op_start, op_state0, op_state1, op_state2, op_state3, round_idx,
        input  op_done, op_result0, op_result1, op_result2, op_result3
    );

    modport slave (
        input  op_sel, op_start, op_state0, op_state1, op_state2, op_state3, round_idx,
        output op_done, op_result0, op_result1, op_result2, op_result3
    );

endinterface

// File: rtl/aes_op_watchdog.sv
// rtl/aes_op_watchdog.sv - counts cycles spent waiting on a round unit; instantiated only with AES_OP_TIMEOUT_EN
module aes_op_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] count;

    // expired fires during the TIMEOUT_CYCLES-th enabled cycle, so the caller leaves WAIT on that edge.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer issuing SB/SR/MC/ARK to shared units and owning the state register
// AES_OP_TIMEOUT_EN adds the op watchdog, the ERR state and a live error flag.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
`ifdef AES_OP_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [31:0]      state0,
    input  logic [31:0]      state1,
    input  logic [31:0]      state2,
    input  logic [31:0]      state3,
    aes_round_ctrl_if.master opbus,
    output logic [31:0]      state_out0,
    output logic [31:0]      state_out1,
    output logic [31:0]      state_out2,
    output logic [31:0]      state_out3,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ctrl_state_t  state, state_nx;
    logic [127:0] sreg, sreg_nx;
    logic [127:0] sout_q, sout_nx;
    aes_op_t      op_q, op_nx;
    logic [3:0]   round_q, round_nx;
    logic         busy_nx;
    logic         done_nx;
    logic         start_q;
    logic         start_edge;
    logic         accept;

`ifdef AES_OP_TIMEOUT_EN
    logic         err_q, err_nx;
    logic         wd_expired;

    aes_op_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expired(wd_expired)
    );

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign start_edge = start_in & ~start_q;

    assign opbus.op_sel    = op_q;
    assign opbus.op_start  = (state == ST_ISSUE);
    assign opbus.round_idx = round_q;
    assign opbus.op_state0 = sreg[31:0];
    assign opbus.op_state1 = sreg[63:32];
    assign opbus.op_state2 = sreg[95:64];
    assign opbus.op_state3 = sreg[127:96];

    assign state_out0 = sout_q[31:0];
    assign state_out1 = sout_q[63:32];
    assign state_out2 = sout_q[95:64];
    assign state_out3 = sout_q[127:96];

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        sout_nx  = sout_q;
        op_nx    = op_q;
        round_nx = round_q;
        busy_nx  = busy;
        done_nx  = 1'b0;
        accept   = 1'b0;
`ifdef AES_OP_TIMEOUT_EN
        err_nx   = err_q;
`endif

        case (state)
            ST_IDLE: accept = start_edge;

            ST_ISSUE: state_nx = ST_WAIT;

            ST_WAIT: begin
                if (opbus.op_done) begin
                    sreg_nx = {opbus.op_result3, opbus.op_result2, opbus.op_result1, opbus.op_result0};
                    if (op_q == OP_ARK && round_q == LAST_ROUND) begin
                        state_nx = ST_FIN;
                    end else begin
                        op_nx = next_op(op_q, round_q == LAST_ROUND);
                        // Each ARK closes a round, so the key index advances with it.
                        if (op_q == OP_ARK) begin
                            round_nx = round_q + 4'd1;
                        end
                        state_nx = ST_ISSUE;
                    end
                end
`ifdef AES_OP_TIMEOUT_EN
                else if (wd_expired) begin
                    state_nx = ST_ERR;
                    busy_nx  = 1'b0;
                    err_nx   = 1'b1;
                end
`endif
            end

            ST_FIN: begin
                sout_nx  = sreg;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end

`ifdef AES_OP_TIMEOUT_EN
            ST_ERR: accept = start_edge;
`endif

            default: state_nx = ST_IDLE;
        endcase

        if (accept) begin
            sreg_nx  = {state3, state2, state1, state0};
            op_nx    = OP_ARK;
            round_nx = 4'd0;
            busy_nx  = 1'b1;
            state_nx = ST_ISSUE;
`ifdef AES_OP_TIMEOUT_EN
            err_nx   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            sout_q  <= '0;
            op_q    <= OP_SB;
            round_q <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
`ifdef AES_OP_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            sreg    <= sreg_nx;
            sout_q  <= sout_nx;
            op_q    <= op_nx;
            round_q <= round_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            start_q <= start_in;
`ifdef AES_OP_TIMEOUT_EN
            err_q   <= err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed bench for aes_round_ctrl with behavioural AES round units
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [31:0] state0, state1, state2, state3;
    logic [31:0] state_out0, state_out1, state_out2, state_out3;
    logic        busy, done, error;

    aes_round_ctrl_if opif ();

    aes_round_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start_in  (start_in),
        .state0    (state0),
        .state1    (state1),
        .state2    (state2),
        .state3    (state3),
        .opbus     (opif),
        .state_out0(state_out0),
        .state_out1(state_out1),
        .state_out2(state_out2),
        .state_out3(state_out3),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   lat        = 3;
    bit   withhold   = 1'b0;
    bit   spur_issue = 1'b0;
    bit   spur_now   = 1'b0;
    int   mc_at_nr   = 0;
    int   done_cnt   = 0;
    logic [1:0] trace_op[$];
    logic [3:0] trace_rd[$];
    logic [1:0] exp_op[$];
    logic [3:0] exp_rd[$];
    logic [7:0] ek[176];

    localparam logic [127:0] KEY     = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] PT_FIPS = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] CT_FIPS = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;
    localparam logic [127:0] JUNK    = 128'hdeadbeef_0badf00d_cafebabe_12345678;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as a^254, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x, inv;
        x = a;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            x = gmul(x, x);
            inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c + r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c +: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic void expand_key(input logic [127:0] key);
        logic [7:0] t0, t1, t2, t3, tmp, rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) ek[i] = key[8*i +: 8];
        for (int i = 16; i < 176; i += 4) begin
            t0 = ek[i-4]; t1 = ek[i-3]; t2 = ek[i-2]; t3 = ek[i-1];
            if (i % 16 == 0) begin
                tmp = t0;
                t0 = sbox(t1) ^ rc;
                t1 = sbox(t2);
                t2 = sbox(t3);
                t3 = sbox(tmp);
                rc = xt(rc);
            end
            ek[i]   = ek[i-16] ^ t0;
            ek[i+1] = ek[i-15] ^ t1;
            ek[i+2] = ek[i-14] ^ t2;
            ek[i+3] = ek[i-13] ^ t3;
        end
    endfunction

    function automatic logic [127:0] round_key(input logic [3:0] rd);
        logic [127:0] k;
        for (int i = 0; i < 16; i++) k[8*i +: 8] = ek[16*rd + i];
        return k;
    endfunction

    function automatic logic [127:0] apply_op(input logic [1:0] op, input logic [3:0] rd, input logic [127:0] s);
        case (op)
            2'd0:    return sub_bytes(s);
            2'd1:    return shift_rows(s);
            2'd2:    return mix_columns(s);
            default: return s ^ round_key(rd);
        endcase
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(4'd0);
        for (int r = 1; r < AES_NR; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ round_key(4'(r));
        return shift_rows(sub_bytes(s)) ^ round_key(4'(AES_NR));
    endfunction

    task automatic drive_result(input logic [127:0] v);
        opif.op_result0 = v[31:0];
        opif.op_result1 = v[63:32];
        opif.op_result2 = v[95:64];
        opif.op_result3 = v[127:96];
    endtask

    // Round units: answer each op_start with op_done lat cycles later.
    initial begin
        int cnt;
        bit pend;
        logic [127:0] res;
        pend = 1'b0;
        cnt = 0;
        res = '0;
        opif.op_done = 1'b0;
        drive_result('0);
        forever begin
            @(posedge clk);
            #1;
            opif.op_done = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (reset) pend = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    drive_result(res);
                    opif.op_done = 1'b1;
                end
            end
            if (opif.op_start === 1'b1) begin
                trace_op.push_back(opif.op_sel);
                trace_rd.push_back(opif.round_idx);
                if (opif.op_sel == OP_MC && opif.round_idx == 4'(AES_NR)) mc_at_nr++;
                if (!withhold) begin
                    pend = 1'b1;
                    cnt = lat;
                    res = apply_op(opif.op_sel, opif.round_idx,
                                   {opif.op_state3, opif.op_state2, opif.op_state1, opif.op_state0});
                end
                if (spur_issue) begin
                    drive_result(JUNK);
                    opif.op_done = 1'b1;
                end
            end
            if (spur_now) begin
                drive_result(JUNK);
                opif.op_done = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic set_pt(input logic [127:0] pt);
        state0 = pt[31:0];
        state1 = pt[63:32];
        state2 = pt[95:64];
        state3 = pt[127:96];
    endtask

    task automatic check_trace();
        check("trace_len", trace_op.size(), exp_op.size());
        for (int i = 0; i < exp_op.size(); i++) begin
            if (i < trace_op.size()) begin
                check($sformatf("trace_op[%0d]", i), trace_op[i], exp_op[i]);
                check($sformatf("trace_rd[%0d]", i), trace_rd[i], exp_rd[i]);
            end
        end
    endtask

    int cyc;
    int dc0;
    int guard;
    logic [127:0] pt2;
    logic [127:0] snap;

    initial begin
        reset = 1'b1;
        start_in = 1'b0;
        set_pt('0);
        expand_key(KEY);

        exp_op.push_back(2'd3);
        exp_rd.push_back(4'd0);
        for (int r = 1; r < AES_NR; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_op.push_back(2'(k));
                exp_rd.push_back(4'(r));
            end
        end
        exp_op.push_back(2'd0); exp_rd.push_back(4'(AES_NR));
        exp_op.push_back(2'd1); exp_rd.push_back(4'(AES_NR));
        exp_op.push_back(2'd3); exp_rd.push_back(4'(AES_NR));

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_op_start", opif.op_start, 1'b0);
        check("rst_op_sel", opif.op_sel, 2'd0);
        check("rst_round_idx", opif.round_idx, 4'd0);
        check("rst_state_out", {state_out3, state_out2, state_out1, state_out0}, 128'h0);
        check("rst_op_state", {opif.op_state3, opif.op_state2, opif.op_state1, opif.op_state0}, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 vector with L=3
        lat = 3;
        set_pt(PT_FIPS);
        trace_op.delete();
        trace_rd.delete();
        start_in = 1'b1;
        @(negedge clk);
        check("acc_busy", busy, 1'b1);
        check("acc_op_start", opif.op_start, 1'b1);
        check("acc_op_sel", opif.op_sel, 2'd3);
        check("acc_round_idx", opif.round_idx, 4'd0);
        check("acc_op_state0", opif.op_state0, 32'h33221100);
        check("acc_op_state3", opif.op_state3, 32'hffeeddcc);
        wait_done(0, cyc);
        check("latency_L3", cyc, 161);
        check("busy_at_done", busy, 1'b0);
        check("ct_fips", {state_out3, state_out2, state_out1, state_out0}, CT_FIPS);
        check_trace();
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("ct_held", state_out0, 32'hd8e0c469);

        // start_in held across done must not retrigger
        repeat (5) @(negedge clk);
        check("held_no_rerun", busy, 1'b0);
        check("held_done_cnt", done_cnt, 1);

        // second run, L=1, start toggled while busy
        start_in = 1'b0;
        pt2 = {PT_FIPS[127:32], 32'h78563412};
        set_pt(pt2);
        lat = 1;
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        check("run2_busy", busy, 1'b1);
        set_pt(PT_FIPS);
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        wait_done(3, cyc);
        check("latency_L1", cyc, 81);
        check("ct_run2", {state_out3, state_out2, state_out1, state_out0}, aes_encrypt(pt2));
        repeat (5) @(negedge clk);
        check("run2_no_rerun", busy, 1'b0);
        check("run2_done_cnt", done_cnt, 2);

        // reset at op #20
        start_in = 1'b0;
        lat = 3;
        @(negedge clk);
        trace_op.delete();
        trace_rd.delete();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        guard = 0;
        while (trace_op.size() < 20 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("reached_op20", trace_op.size(), 20);
        dc0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_op_start", opif.op_start, 1'b0);
        check("mid_rst_op_sel", opif.op_sel, 2'd0);
        check("mid_rst_round_idx", opif.round_idx, 4'd0);
        check("mid_rst_state_out", {state_out3, state_out2, state_out1, state_out0}, 128'h0);
        check("mid_rst_op_state", {opif.op_state3, opif.op_state2, opif.op_state1, opif.op_state0}, 128'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_done", done_cnt, dc0);
        check("mid_rst_idle", busy, 1'b0);
        trace_op.delete();
        trace_rd.delete();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        wait_done(0, cyc);
        check("latency_after_rst", cyc, 161);
        check("ct_after_rst", {state_out3, state_out2, state_out1, state_out0}, CT_FIPS);
        repeat (2) @(negedge clk);

        // spurious op_done in IDLE, then in every ISSUE cycle
        snap = {opif.op_state3, opif.op_state2, opif.op_state1, opif.op_state0};
        spur_now = 1'b1;
        @(negedge clk);
        spur_now = 1'b0;
        @(negedge clk);
        check("spur_idle_sreg", {opif.op_state3, opif.op_state2, opif.op_state1, opif.op_state0}, snap);
        check("spur_idle_out", {state_out3, state_out2, state_out1, state_out0}, CT_FIPS);
        check("spur_idle_busy", busy, 1'b0);
        spur_issue = 1'b1;
        trace_op.delete();
        trace_rd.delete();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        wait_done(0, cyc);
        spur_issue = 1'b0;
        check("latency_spur", cyc, 161);
        check("ct_spur", {state_out3, state_out2, state_out1, state_out0}, CT_FIPS);
        check("spur_trace_len", trace_op.size(), 40);
        check("no_mc_final_round", mc_at_nr, 0);

`ifdef AES_OP_TIMEOUT_EN
        // withheld op_done trips the watchdog
        @(negedge clk);
        dc0 = done_cnt;
        withhold = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (error !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, 65);
        check("timeout_error", error, 1'b1);
        check("timeout_busy", busy, 1'b0);
        start_in = 1'b0;
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        check("err_holds", error, 1'b1);
        check("err_no_done", done_cnt, dc0);
        start_in = 1'b1;
        @(negedge clk);
        check("err_cleared", error, 1'b0);
        check("err_restart_busy", busy, 1'b1);
        wait_done(0, cyc);
        check("latency_after_err", cyc, 161);
        check("ct_after_err", {state_out3, state_out2, state_out1, state_out0}, CT_FIPS);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
